// File: rtl/databus_pkg.sv
// Shared MDU opcode encoding and controller constants.
// MDU_MADD_EN, when defined, enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package databus_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8,
        MADD  = 4'd9,
        MADDU = 4'd10,
        MSUB  = 4'd11,
        MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;
    localparam int MDU_CNT_W   =
        $clog2(((MDU_MUL_LAT > MDU_DIV_LAT) ? MDU_MUL_LAT : MDU_DIV_LAT) + 1);

endpackage

// File: rtl/mdu_datapath.sv
// Combinational MDU arithmetic: full 64-bit result for the op plus divide-by-zero flag.
// MDU_MADD_EN adds the accumulate variants against the current {hi,lo}.
module mdu_datapath
    import databus_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    mdu_op_e     op_e;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign op_e = mdu_op_e'(op);

    always_comb begin
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'b0, a} * {32'b0, b};

        // Sign-magnitude divide: abs(0x80000000) stays 0x80000000 as unsigned,
        // so the INT_MIN / -1 case wraps to 0x80000000 without special casing.
        a_neg   = (op_e == DIV) & a[31];
        b_neg   = (op_e == DIV) & b[31];
        mag_a   = a_neg ? (32'd0 - a) : a;
        mag_b   = b_neg ? (32'd0 - b) : b;
        divisor = (b == 32'd0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;

        div0    = ((op_e == DIV) || (op_e == DIVU)) && (b == 32'd0);

        {res_hi, res_lo} = {hi, lo};
        case (op_e)
            MULT:        {res_hi, res_lo} = prod_s;
            MULTU:       {res_hi, res_lo} = prod_u;
            DIV, DIVU:   {res_hi, res_lo} = {rem, quot};
`ifdef MDU_MADD_EN
            MADD:        {res_hi, res_lo} = {hi, lo} + prod_s;
            MADDU:       {res_hi, res_lo} = {hi, lo} + prod_u;
            MSUB:        {res_hi, res_lo} = {hi, lo} - prod_s;
            MSUBU:       {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default:     {res_hi, res_lo} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: HI/LO state, fixed-latency long ops and busy for the stall controller.
// MDU_MADD_EN, when defined, accepts MADD/MADDU/MSUB/MSUBU as long ops with MUL_LAT.
module mdu_unit
    import databus_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1);

    mdu_op_e     op_e;
    mdu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_div0_q, pend_div0_d;
    logic [31:0] res_hi, res_lo;
    logic        div0;
    logic        go;
    logic        long_op;
    logic        div_op;

    assign op_e = mdu_op_e'(op);

    mdu_datapath u_datapath (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    always_comb begin
        go     = start & ~cancel & (cnt_q == '0);
        div_op = (op_e == DIV) || (op_e == DIVU);
        case (op_e)
            MULT, MULTU, DIV, DIVU:    long_op = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU:  long_op = 1'b1;
`endif
            default:                   long_op = 1'b0;
        endcase

        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;

        case (state_q)
            ST_IDLE: begin
                if (go && long_op) begin
                    state_d     = ST_RUN;
                    cnt_d       = div_op ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                    pend_hi_d   = res_hi;
                    pend_lo_d   = res_lo;
                    pend_div0_d = div0;
                end else if (go && (op_e == MTHI)) begin
                    hi_d = a;
                end else if (go && (op_e == MTLO)) begin
                    lo_d = a;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    // Divide by zero keeps the full latency but leaves HI/LO alone.
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy  = (state_q == ST_RUN) | (go & long_op);
        rdata = (op_e == MFHI) ? hi_q : (op_e == MFLO) ? lo_q : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_div0_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
